// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } muldiv_state_t;

  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned CNT_W    = $clog2(MD_ITERS);

  // Magnitude of a two's-complement word when the op is signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared engine: shift-add multiply or restoring divide
// on the 64-bit working register {upper, lower}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div_i,
  input  logic [63:0] work_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] work_o
);

  logic [32:0] sum;
  logic [32:0] rem_shift;
  logic [31:0] diff;

  always_comb begin
    // Multiply: conditionally add multiplicand to the accumulator, keep the carry.
    sum       = {1'b0, work_i[63:32]} + (work_i[0] ? {1'b0, opnd_i} : 33'd0);
    // Divide: partial remainder shifted left with the next dividend bit.
    rem_shift = work_i[63:31];
    diff      = rem_shift[31:0] - opnd_i;
    work_o    = {sum, work_i[31:1]};
    if (is_div_i) begin
      if (rem_shift >= {1'b0, opnd_i}) begin
        work_o = {diff, work_i[30:0], 1'b1};
      end else begin
        work_o = {rem_shift[31:0], work_i[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: sequences 32-iteration mul/div ops, handles MTHI/MTLO and
// raises stall for any HI/LO or engine request while busy.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        dz
);

  muldiv_state_t    state_q;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      work_q;
  logic [63:0]      work_d;
  logic [31:0]      opnd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic [63:0]      prod;

  muldiv_step u_step (
    .is_div_i (op_q[1]),
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .work_o   (work_d)
  );

  // Sign correction applied on the FIX edge.
  always_comb begin
    prod   = work_q;
    res_hi = work_q[63:32];
    res_lo = work_q[31:0];
    if (op_q == OP_MULT && neg_quo_q) begin
      prod = ~work_q + 64'd1;
    end
    if (op_q[1]) begin
      if (op_q == OP_DIV && neg_quo_q) res_lo = ~work_q[31:0] + 32'd1;
      if (op_q == OP_DIV && neg_rem_q) res_hi = ~work_q[63:32] + 32'd1;
      // The remainder path already reproduces the original dividend for b == 0.
      if (div0_q) res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULTU;
      cnt_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q      <= muldiv_op_t'(op);
            opnd_q    <= abs32(b, op[0]);
            work_q    <= {32'd0, abs32(a, op[0])};
            neg_quo_q <= op[0] & (a[31] ^ b[31]);
            neg_rem_q <= op[0] & a[31];
            div0_q    <= op[1] & (b == 32'd0);
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dz_q      <= 1'b0;
            state_q   <= ST_RUN;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        ST_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MD_ITERS - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          dz_q    <= div0_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;
  assign stall = busy_q & (start | hilo_rd | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench: arithmetic reference model compared every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hilo_rd = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dz;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_done, m_dz, r_dz;
  int          m_busy_cnt = 0;

  logic [31:0] rq_hi[$];
  logic [31:0] rq_lo[$];
  int          rq_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  function automatic void golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint      sx, sy, q, r;
    logic [63:0] t;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    rdz = 1'b0;
    case (o)
      2'b00: begin t = {32'd0, x} * {32'd0, y}; rh = t[63:32]; rl = t[31:0]; end
      2'b01: begin t = sx * sy; rh = t[63:32]; rl = t[31:0]; end
      default: begin
        if (y == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = x; rdz = 1'b1;
        end else if (o == 2'b10) begin
          rl = x / y; rh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          t = q; rl = t[31:0];
          t = r; rh = t[31:0];
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_valid = 1'b1; m_hi = '0; m_lo = '0; m_busy_cnt = 0; m_done = 1'b0; m_dz = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_dz = r_dz; m_done = 1'b1;
        end
      end else if (start) begin
        golden(op, a, b, r_hi, r_lo, r_dz);
        m_busy_cnt = 33;
        m_dz = 1'b0;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk1("busy", busy, m_busy_cnt != 0);
      chk1("done", done, m_done);
      chk1("dz", dz, m_dz);
      chk1("stall", stall, (m_busy_cnt != 0) && (start || hilo_rd || hi_we || lo_we));
      if (done) begin
        rq_hi.push_back(hi); rq_lo.push_back(lo); rq_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit idle;
    int budget = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    forever begin
      @(negedge clk);
      idle = (m_busy_cnt == 0);
      @(posedge clk); #1;
      if (idle) break;
      budget++;
      if (budget > 100) begin
        total++;
        $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_result(input string nm, input logic [31:0] eh, input logic [31:0] el, output int c);
    int n = 0;
    c = 0;
    while (rq_hi.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (rq_hi.size() == 0) begin
      total++;
      $display("FAIL %s_done: got no done pulse expected one within 100 cycles", nm);
    end else begin
      logic [31:0] gh, gl;
      gh = rq_hi.pop_front(); gl = rq_lo.pop_front(); c = rq_cyc.pop_front();
      $display("op %s: hi=%h lo=%h (cycle %0d)", nm, gh, gl, c);
      chk({nm, "_hi"}, gh, eh);
      chk({nm, "_lo"}, gl, el);
    end
  endtask

  initial begin
    int n, c1, c2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk1("reset_busy", busy, 1'b0);

    // MULTU max*max, 33 busy cycles
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_cycles", n, 33);
    wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, c1);

    // MULT -3*7 with MFLO two cycles in
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hilo_rd = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (stall) n++;
    end
    chk("mflo_stall_cycles", n, 31);
    @(posedge clk); #1;
    hilo_rd = 1'b0;
    wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, c1);

    // DIV -7/2 then DIVU 100/7 held under stall, accepted in the done cycle
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 32'd100, 32'd7);
    wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, c1);
    wait_result("divu_b2b", 32'd2, 32'd14, c2);
    chk("b2b_gap", c2 - c1, 34);

    // Divide by zero, then signed overflow clears dz
    issue(2'b10, 32'd5, 32'd0);
    wait_result("divu_zero", 32'd5, 32'hFFFF_FFFF, c1);
    chk1("dz_set", dz, 1'b1);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk1("dz_clear", dz, 1'b0);
    wait_result("div_ovf", 32'd0, 32'h8000_0000, c1);

    // MTHI while busy lands only after the op completes
    issue(2'b00, 32'h0001_0000, 32'h0003_0000);
    hi_we = 1'b1; wdata = 32'h1234;
    wait_result("multu_mthi", 32'd3, 32'd0, c1);
    hi_we = 1'b0;
    chk("mthi_after", hi, 32'h1234);

    // Reset during a DIV discards it
    issue(2'b11, 32'hFFFF_FF00, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    repeat (40) begin @(posedge clk); #1; end
    chk("rst_no_done", rq_hi.size(), 0);
    issue(2'b00, 32'd3, 32'd4);
    wait_result("multu_3x4", 32'd0, 32'd12, c1);

    // Randomized traffic, checked every cycle against the model
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 7) == 0);
      op      = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      hilo_rd = ($urandom_range(0, 4) == 0);
      hi_we   = ($urandom_range(0, 6) == 0);
      lo_we   = ($urandom_range(0, 6) == 0);
      wdata   = $urandom;
      rst     = ($urandom_range(0, 399) != 0);
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rst = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
